// File: rtl/fifo_pkg.sv
// Shared FIFO helpers and the default geometry used by the UART top level.
package fifo_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_FIFO_DEPTH = 16;

    // Constant-evaluable ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_fifo_if.sv
// Host/engine-side bundle of the UART FIFO: push/pop requests, read data and status.
interface uart_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) ();

    localparam int ADDR_WIDTH = clog2(FIFO_DEPTH);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, data_in, rd_en, err_clr,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, err_clr,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_dpram.sv
// Register-array storage: synchronous write port, asynchronous read port, no reset.
module fifo_dpram #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= data_in;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO between the UART shift engines and the host registers:
// pointers, fill count, level flags, sticky error flags and registered/FWFT read.
module uart_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = UART_DATA_WIDTH,
    parameter int FIFO_DEPTH    = UART_FIFO_DEPTH,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic        clk,
    input  logic        rst,
    uart_fifo_if.slave  bus
);

    localparam int ADDR_WIDTH = clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPT_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == DEPTH_C);
    assign w_rd_acc = bus.rd_en & ~w_empty;
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign w_wr_acc = bus.wr_en & (~w_full | w_rd_acc);

    fifo_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr),
        .data_in (bus.data_in),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky errors: a rejection in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && !w_wr_acc) r_overflow <= 1'b1;
            else if (bus.err_clr)       r_overflow <= 1'b0;
            if (bus.rd_en && !w_rd_acc) r_underflow <= 1'b1;
            else if (bus.err_clr)       r_underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = w_rd_data;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_data_out;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data_out <= '0;
                end else if (w_rd_acc) begin
                    r_data_out <= w_rd_data;
                end
            end
            assign bus.data_out = r_data_out;
        end
    endgenerate

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= AFULL_C);
    assign bus.almost_empty = (r_count <= AEMPT_C);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_uart_fifo.sv
// Drives a registered-read and an FWFT FIFO with identical directed stimulus and
// checks both against a queue model every cycle, plus hand-computed expectations.
module tb_uart_fifo;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    uart_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) bus0 ();
    uart_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) bus1 ();

    uart_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(0))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Reference model: contents as a queue, registered read word and sticky errors.
    logic [7:0] q [$];
    logic [7:0] m_dout0;
    logic       m_ovf;
    logic       m_udf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_dout0 = 8'h00;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic cyc(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
        int  n;
        bit  ra;
        bit  wa;
        bus0.wr_en = wr;  bus0.data_in = din;  bus0.rd_en = rd;  bus0.err_clr = clr;
        bus1.wr_en = wr;  bus1.data_in = din;  bus1.rd_en = rd;  bus1.err_clr = clr;
        @(posedge clk);
        n  = q.size();
        ra = rd && (n > 0);
        wa = wr && ((n < 16) || ra);
        if (wr && !wa) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (rd && !ra) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
        if (ra) m_dout0 = q.pop_front();
        if (wa) q.push_back(din);
        #1;
        bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.err_clr = 1'b0;
        bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.err_clr = 1'b0;
    endtask

    // Per-cycle compare of both DUTs against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count0", 32'(bus0.count), 32'(q.size()));
            chk("count1", 32'(bus1.count), 32'(q.size()));
            chk("empty0", 32'(bus0.empty), 32'(q.size() == 0));
            chk("empty1", 32'(bus1.empty), 32'(q.size() == 0));
            chk("full0", 32'(bus0.full), 32'(q.size() == 16));
            chk("full1", 32'(bus1.full), 32'(q.size() == 16));
            chk("afull0", 32'(bus0.almost_full), 32'(q.size() >= 12));
            chk("afull1", 32'(bus1.almost_full), 32'(q.size() >= 12));
            chk("aempty0", 32'(bus0.almost_empty), 32'(q.size() <= 4));
            chk("aempty1", 32'(bus1.almost_empty), 32'(q.size() <= 4));
            chk("ovf0", 32'(bus0.overflow), 32'(m_ovf));
            chk("ovf1", 32'(bus1.overflow), 32'(m_ovf));
            chk("udf0", 32'(bus0.underflow), 32'(m_udf));
            chk("udf1", 32'(bus1.underflow), 32'(m_udf));
            chk("dout0", 32'(bus0.data_out), 32'(m_dout0));
            if (q.size() > 0) chk("dout1", 32'(bus1.data_out), 32'(q[0]));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus0.wr_en = 1'b0; bus0.data_in = 8'h00; bus0.rd_en = 1'b0; bus0.err_clr = 1'b0;
        bus1.wr_en = 1'b0; bus1.data_in = 8'h00; bus1.rd_en = 1'b0; bus1.err_clr = 1'b0;
        model_clear();
        #3;
        chk("rst_count", 32'(bus0.count), 32'd0);
        chk("rst_empty", 32'(bus0.empty), 32'd1);
        chk("rst_full", 32'(bus0.full), 32'd0);
        chk("rst_aempty", 32'(bus0.almost_empty), 32'd1);
        chk("rst_afull", 32'(bus0.almost_full), 32'd0);
        chk("rst_dout0", 32'(bus0.data_out), 32'd0);
        chk("rst_ovf", 32'(bus0.overflow), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Fill with 0x01..0x10; almost_full first rises on the 12th push.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 11) chk("afull_at11", 32'(bus0.almost_full), 32'd0);
            if (i == 12) chk("afull_at12", 32'(bus0.almost_full), 32'd1);
        end
        chk("fill_full", 32'(bus0.full), 32'd1);
        chk("fill_count", 32'(bus0.count), 32'd16);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_set", 32'(bus0.overflow), 32'd1);
        chk("ovf_count", 32'(bus0.count), 32'd16);

        // Drain; data appears one cycle after each pop request.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_dout", 32'(bus0.data_out), 32'(i));
            chk("drain_aempty", 32'(bus0.almost_empty), 32'((16 - i) <= 4));
        end
        chk("drain_empty", 32'(bus0.empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(bus0.overflow), 32'd0);

        // Empty: simultaneous push+pop rejects the pop, push lands.
        cyc(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("udf_set", 32'(bus0.underflow), 32'd1);
        chk("udf_count", 32'(bus0.count), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("udf_clr", 32'(bus0.underflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pop_a5", 32'(bus0.data_out), 32'hA5);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("udf_set_wins", 32'(bus0.underflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Full: simultaneous push+pop both accepted.
        for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("fullrw_count", 32'(bus0.count), 32'd16);
        chk("fullrw_ovf", 32'(bus0.overflow), 32'd0);
        chk("fullrw_dout", 32'(bus0.data_out), 32'h31);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            if (i == 15) chk("fullrw_last_old", 32'(bus0.data_out), 32'h40);
        end
        chk("fullrw_77", 32'(bus0.data_out), 32'h77);

        // Wrap-around at a steady level of 3.
        for (int b = 0; b < 3; b++) cyc(1'b1, 8'(b), 1'b0, 1'b0);
        for (int j = 0; j < 40; j++) begin
            cyc(1'b1, 8'(j + 3), 1'b1, 1'b0);
            if (j == 0) chk("wrap_first", 32'(bus0.data_out), 32'd0);
        end
        chk("wrap_last", 32'(bus0.data_out), 32'd39);
        chk("wrap_count", 32'(bus0.count), 32'd3);
        for (int j = 0; j < 3; j++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_drain", 32'(bus0.data_out), 32'd42);

        // FWFT: pushed word visible without a pop; async reset mid-stream.
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("fwft_dout", 32'(bus1.data_out), 32'h3C);
        chk("fwft_empty", 32'(bus1.empty), 32'd0);
        for (int i = 1; i <= 6; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus1.count), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk("arst_count1", 32'(bus1.count), 32'd0);
        chk("arst_empty1", 32'(bus1.empty), 32'd1);
        chk("arst_count0", 32'(bus0.count), 32'd0);
        model_clear();
        @(negedge clk);
        #1 rst = 1'b0;
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("post_rst_fwft", 32'(bus1.data_out), 32'h5A);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_reg", 32'(bus0.data_out), 32'h5A);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised synchronous FIFO with full pointer and flag control, built around a dual-port register-array memory. It buffers bytes between the UART receiver/transmitter shift engines and the host-side register interface. It supports depth and width generalisation, programmable almost-full/almost-empty thresholds, a fill-level output, sticky error flags, and a selectable first-word-fall-through read mode.

## Interface
- DATA_WIDTH, 8: word width in bits.
- FIFO_DEPTH, 16: number of entries; power of two, ≥ 2.
- AFULL_THRESH, 12: almost_full asserts when count ≥ this value; range 1..FIFO_DEPTH.
- AEMPTY_THRESH, 4: almost_empty asserts when count ≤ this value; range 0..FIFO_DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word fall-through.
- Localparam ADDR_WIDTH = clog2(FIFO_DEPTH); not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  push request.
- data_in  in  DATA_WIDTH  push data.
- rd_en  in  1  pop request.
- err_clr  in  1  clears the overflow and underflow flags.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_THRESH.
- almost_empty  out  1  count ≤ AEMPTY_THRESH.
- count  out  ADDR_WIDTH+1  current fill level, 0..FIFO_DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation
- State: wr_ptr and rd_ptr (ADDR_WIDTH bits each, natural wrap from FIFO_DEPTH-1 to 0), count register (ADDR_WIDTH+1 bits), data_out register (FWFT=0 only), overflow and underflow registers.
- Read accept: rd_acc = rd_en & ~empty.
- Write accept: wr_acc = wr_en & (~full | rd_acc). A push into a full FIFO succeeds only when a pop is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] ← data_in, and wr_ptr increments.
- On rd_acc: rd_ptr increments.
- count: +1 on wr_acc only, −1 on rd_acc only, and unchanged when both or neither are accepted. count never exceeds FIFO_DEPTH and never goes below 0.
- When empty, a read is rejected even if wr_en is high in the same cycle. No write-to-read bypass.
- All flags are derived combinationally from the count register only, so they change only on clock edges.
- FWFT=0: on rd_acc, data_out ← mem[rd_ptr] at the edge. Otherwise data_out holds its value.
- FWFT=1: data_out = mem[rd_ptr] combinationally whenever ~empty. rd_en acknowledges (pops) the displayed word. data_out is don't-care while empty; the bench must not check it then.
- overflow is set on wr_en & ~wr_acc. underflow is set on rd_en & ~rd_acc. err_clr clears both. If a set and err_clr occur in the same cycle, set wins.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, data_out=0 (FWFT=0). Memory contents are not reset.
- rst asserted mid-operation discards all contents immediately, asynchronously. The first write after deassertion lands at address 0.

## Timing
- Write latency: a push at edge N is reflected in count, empty and the other flags after edge N.
- FWFT=1: the pushed word is visible on data_out in the cycle after edge N.
- FWFT=0 read: rd_en sampled at edge N; data_out is valid after edge N, with 1-cycle latency.
- Throughput: one push and one pop per cycle, sustained, at any fill level.
- Flags are not look-ahead. A producer sampling full in the same cycle as a pop must rely on the simultaneous-accept rule above.

## Structure
- Shared package/header fifo_pkg:
  - clog2 function.
  - Default DATA_WIDTH and FIFO_DEPTH constants used by the UART top level.
- Sub-module fifo_dpram:
  - Register array FIFO_DEPTH × DATA_WIDTH.
  - Synchronous write port (wr_en, wr_addr, data_in).
  - Asynchronous read port (rd_addr → rd_data).
  - No reset.
- uart_fifo contains pointers, count, flags, error logic and the FWFT mux/register.

## Test plan
- Reset, then push 0x01..0x10 (16 words) -> full=1, count=16, almost_full first high after the 12th push. A 17th push with rd_en=0 is rejected, sets overflow=1, and leaves contents unchanged.
- From full, pop all 16 (FWFT=0) -> data_out sequence 0x01..0x10, each valid 1 cycle after rd_en. empty=1 after the last pop. almost_empty asserts when count reaches 4.
- Empty FIFO: rd_en=1 with wr_en=1 and data 0xA5 -> read rejected, underflow=1, count=1. Next cycle err_clr=1 -> underflow=0. Simultaneous underflow set and err_clr -> underflow stays 1.
- Full FIFO: wr_en=1 and rd_en=1 with data 0x77 -> both accepted, count stays 16, no overflow. 0x77 is popped after the 15 older words.
- Wrap-around: 40 cycles of interleaved push/pop of an incrementing byte at count ≈ 3 -> output is in order with no loss. Pointers wrap past 15 at least twice.
- FWFT=1 build: push 0x3C into an empty FIFO -> data_out=0x3C and empty=0 in the next cycle without rd_en. Assert rst mid-stream with count=7 -> count=0, empty=1 immediately; the next push is readable first.
